// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding and the access-legality helper used on request accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

  // True when the width code is illegal for the access direction or the byte
  // offset is not aligned to the access width. Range is checked separately.
  function automatic logic lsu_bad_access(input logic       isStore,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = isStore;
      F3_H:    bad = offset[0];
      F3_HU:   bad = isStore | offset[0];
      F3_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: pulls a byte/half/word out of a
// memory word with sign or zero extension, and merges store data into an
// existing word for byte/half read-modify-write. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_loadWord,
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_storeData,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergedWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane (little-endian) and extend it to 32 bits.
  always_comb begin
    w_byte     = i_loadWord[{i_offset, 3'b000} +: 8];
    w_half     = i_loadWord[{i_offset[1], 4'b0000} +: 16];
    o_loadData = i_loadWord;
    case (i_funct3)
      F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_loadData = {24'h000000, w_byte};
      F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
      F3_HU:   o_loadData = {16'h0000, w_half};
      default: o_loadData = i_loadWord;
    endcase
  end

  // Replace the addressed lane of the old word with the low store bits.
  always_comb begin
    o_mergedWord = i_oldWord;
    case (i_funct3)
      F3_B:    o_mergedWord[{i_offset, 3'b000} +: 8] = i_storeData[7:0];
      F3_H:    o_mergedWord[{i_offset[1], 4'b0000} +: 16] = i_storeData[15:0];
      default: o_mergedWord = i_storeData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one request at a time, checks it,
// then reads, writes or read-modify-writes a word-addressed data memory and
// returns a single-cycle response with extended load data and an error flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] WORD_LIMIT = 30'(ADDR_WORDS);

  lsu_state_t  r_state;
  lsu_state_t  w_nextState;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rmwWord;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_reqBad;
  logic [31:0] w_wordIndex;
  logic [31:0] w_loadData;
  logic [31:0] w_mergedWord;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_reqBad    = lsu_bad_access(req_we, req_funct3, req_addr[1:0]) ||
                       (req_addr[31:2] >= WORD_LIMIT);
  assign w_wordIndex = {2'b00, r_addr[31:2]};
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_addr[1:0]),
    .i_loadWord   (mem_rdata),
    .i_oldWord    (r_rmwWord),
    .i_storeData  (r_wdata),
    .o_loadData   (w_loadData),
    .o_mergedWord (w_mergedWord)
  );

  // State register; reset abandons any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and memory/handshake outputs; memory buses stay at
  // zero whenever neither enable is asserted.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_reqBad) begin
            w_nextState = RESP;
          end else if (!req_we) begin
            w_nextState = LOAD;
          end else if (req_funct3 == F3_W) begin
            w_nextState = WRITE;
          end else begin
            w_nextState = RMW_READ;
          end
        end
      end
      LOAD: begin
        mem_read    = 1'b1;
        mem_addr    = w_wordIndex;
        w_nextState = RESP;
      end
      RMW_READ: begin
        mem_read    = 1'b1;
        mem_addr    = w_wordIndex;
        w_nextState = WRITE;
      end
      WRITE: begin
        mem_write   = r_we;
        mem_addr    = w_wordIndex;
        mem_wdata   = w_mergedWord;
        w_nextState = RESP;
      end
      RESP: begin
        resp_valid  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, RMW word capture and the held response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_rmwWord <= 32'h0;
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        if (w_reqBad) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == LOAD) begin
        r_rdata <= w_loadData;
        r_err   <= 1'b0;
      end
      if (r_state == RMW_READ) begin
        r_rmwWord <= mem_rdata;
      end
      if (r_state == WRITE) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed requests against a
// 128-word memory model, plus reset-in-flight and back-to-back sequences.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:127];
  logic        presetEn;
  logic [6:0]  presetIdx;
  logic [31:0] presetVal;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  readMask;
    logic [7:0]  writeMask;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.ADDR_WORDS(128)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = (mem_read && mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'h0;

  always @(posedge clock) begin
    if (mem_write && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
    else if (presetEn) mem[presetIdx] <= presetVal;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic presetWord(input int idx, input logic [31:0] val);
    @(negedge clock);
    presetEn  = (idx < 128);
    presetIdx = idx[6:0];
    presetVal = val;
    @(negedge clock);
    presetEn  = 1'b0;
  endtask

  function automatic void addVec(input string name, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input logic [31:0] rdata, input logic err,
                                 input logic [7:0] rdMask, input logic [7:0] wrMask,
                                 input logic [31:0] word);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata; v.err = err;
    v.readMask = rdMask; v.writeMask = wrMask; v.word = word;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    int         idx;
    int         respK;
    int         respCount;
    logic [7:0] rdSeen;
    logic [7:0] wrSeen;
    idx = int'(v.addr[31:2]);
    presetWord(idx, 32'h8899AABB);
    checkOutput({v.name, " ready before"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    respK = 0; respCount = 0; rdSeen = 8'h00; wrSeen = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (mem_read)  rdSeen[k] = 1'b1;
      if (mem_write) wrSeen[k] = 1'b1;
      if (mem_read || mem_write) begin
        checkOutput({v.name, " mem_addr"}, mem_addr, {2'b00, v.addr[31:2]});
      end else begin
        checkOutput({v.name, " idle mem_addr"}, mem_addr, 32'h0);
      end
      if (mem_write) checkOutput({v.name, " mem_wdata"}, mem_wdata, v.word);
      else           checkOutput({v.name, " idle mem_wdata"}, mem_wdata, 32'h0);
      if (resp_valid) begin
        respCount++;
        if (respK == 0) respK = k;
        checkOutput({v.name, " rdata"}, resp_rdata, v.rdata);
        checkOutput({v.name, " err"}, {31'b0, resp_err}, {31'b0, v.err});
      end
    end
    checkOutput({v.name, " latency"}, 32'(respK), 32'(v.lat));
    checkOutput({v.name, " resp count"}, 32'(respCount), 32'd1);
    checkOutput({v.name, " read cycles"}, {24'b0, rdSeen}, {24'b0, v.readMask});
    checkOutput({v.name, " write cycles"}, {24'b0, wrSeen}, {24'b0, v.writeMask});
    checkOutput({v.name, " rdata hold"}, resp_rdata, v.rdata);
    checkOutput({v.name, " err hold"}, {31'b0, resp_err}, {31'b0, v.err});
    if (idx < 128) checkOutput({v.name, " mem word"}, mem[idx], v.word);
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    presetEn = 1'b0; presetIdx = 7'd0; presetVal = 32'h0;
    checks = 0; errors = 0;

    //      name          we  f3      addr          wdata         lat rdata         err rd     wr     word
    addVec("LW 0x10",     0, 3'b010, 32'h00000010, 32'h0,        2, 32'h8899AABB, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LB 0x13",     0, 3'b000, 32'h00000013, 32'h0,        2, 32'hFFFFFF88, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LBU 0x13",    0, 3'b100, 32'h00000013, 32'h0,        2, 32'h00000088, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LH 0x12",     0, 3'b001, 32'h00000012, 32'h0,        2, 32'hFFFF8899, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LHU 0x10",    0, 3'b101, 32'h00000010, 32'h0,        2, 32'h0000AABB, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LB 0x10",     0, 3'b000, 32'h00000010, 32'h0,        2, 32'hFFFFFFBB, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LBU 0x11",    0, 3'b100, 32'h00000011, 32'h0,        2, 32'h000000AA, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LW last",     0, 3'b010, 32'h000001FC, 32'h0,        2, 32'h8899AABB, 0, 8'h02, 8'h00, 32'h8899AABB);
    addVec("LH odd",      0, 3'b001, 32'h00000011, 32'h0,        1, 32'h00000000, 1, 8'h00, 8'h00, 32'h8899AABB);
    addVec("SB 0x11",     1, 3'b000, 32'h00000011, 32'h000000CC, 3, 32'h00000000, 0, 8'h02, 8'h04, 32'h8899CCBB);
    addVec("SH 0x12",     1, 3'b001, 32'h00000012, 32'h12345678, 3, 32'h00000000, 0, 8'h02, 8'h04, 32'h5678AABB);
    addVec("SB 0x13",     1, 3'b000, 32'h00000013, 32'hFFFFFF7F, 3, 32'h00000000, 0, 8'h02, 8'h04, 32'h7F99AABB);
    addVec("SW 0x10",     1, 3'b010, 32'h00000010, 32'hDEADBEEF, 2, 32'h00000000, 0, 8'h00, 8'h02, 32'hDEADBEEF);
    addVec("LW 0x12",     0, 3'b010, 32'h00000012, 32'h0,        1, 32'h00000000, 1, 8'h00, 8'h00, 32'h8899AABB);
    addVec("SW 0x200",    1, 3'b010, 32'h00000200, 32'h11111111, 1, 32'h00000000, 1, 8'h00, 8'h00, 32'h0);
    addVec("f3 011",      0, 3'b011, 32'h00000010, 32'h0,        1, 32'h00000000, 1, 8'h00, 8'h00, 32'h8899AABB);
    addVec("store BU",    1, 3'b100, 32'h00000010, 32'h000000CC, 1, 32'h00000000, 1, 8'h00, 8'h00, 32'h8899AABB);
    addVec("LB 0x200",    0, 3'b000, 32'h00000200, 32'h0,        1, 32'h00000000, 1, 8'h00, 8'h00, 32'h0);
    addVec("SH 0x13",     1, 3'b001, 32'h00000013, 32'h0000BEEF, 1, 32'h00000000, 1, 8'h00, 8'h00, 32'h8899AABB);
    addVec("LHU after",   0, 3'b101, 32'h00000012, 32'h0,        2, 32'h00008899, 0, 8'h02, 8'h00, 32'h8899AABB);

    // Outputs while reset is held
    #12;
    checkOutput("reset req_ready",  {31'b0, req_ready},  32'd1);
    checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset resp_rdata", resp_rdata,          32'h0);
    checkOutput("reset resp_err",   {31'b0, resp_err},   32'd0);
    checkOutput("reset mem_read",   {31'b0, mem_read},   32'd0);
    checkOutput("reset mem_write",  {31'b0, mem_write},  32'd0);
    checkOutput("reset mem_addr",   mem_addr,            32'h0);
    checkOutput("reset mem_wdata",  mem_wdata,           32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset arriving while an SB is in its RMW read
    begin
      int badResp;
      int badWrite;
      presetWord(4, 32'h8899AABB);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h00000011; req_wdata = 32'h000000CC;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      #2;
      checkOutput("rst-rmw in RMW_READ", {31'b0, mem_read}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rst-rmw ready now",     {31'b0, req_ready}, 32'd1);
      checkOutput("rst-rmw mem_read now",  {31'b0, mem_read},  32'd0);
      checkOutput("rst-rmw mem_addr now",  mem_addr,           32'h0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      badResp = 0; badWrite = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clock);
        if (resp_valid) badResp++;
        if (mem_write)  badWrite++;
      end
      checkOutput("rst-rmw no resp",     32'(badResp),       32'd0);
      checkOutput("rst-rmw no write",    32'(badWrite),      32'd0);
      checkOutput("rst-rmw mem word",    mem[4],             32'h8899AABB);
      checkOutput("rst-rmw ready after", {31'b0, req_ready}, 32'd1);
    end

    // Back-to-back requests with req_valid held high
    presetWord(4, 32'h8899AABB);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h00000010; req_wdata = 32'h0;
    @(posedge clock);
    #1;
    req_funct3 = 3'b100; req_addr = 32'h00000013;
    @(negedge clock);
    checkOutput("b2b k1 ready", {31'b0, req_ready},  32'd0);
    checkOutput("b2b k1 resp",  {31'b0, resp_valid}, 32'd0);
    @(negedge clock);
    checkOutput("b2b k2 ready", {31'b0, req_ready},  32'd0);
    checkOutput("b2b k2 resp",  {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b k2 rdata", resp_rdata,          32'h8899AABB);
    @(negedge clock);
    checkOutput("b2b k3 ready", {31'b0, req_ready},  32'd1);
    checkOutput("b2b k3 resp",  {31'b0, resp_valid}, 32'd0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b k4 ready", {31'b0, req_ready},  32'd0);
    checkOutput("b2b k4 read",  {31'b0, mem_read},   32'd1);
    @(negedge clock);
    checkOutput("b2b k5 resp",  {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b k5 rdata", resp_rdata,          32'h00000088);
    checkOutput("b2b k5 err",   {31'b0, resp_err},   32'd0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
